// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - note event to voice allocator with F/A write bus
// Converts note-on/off events into one-hot F/A load strobes and per-voice gates.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int F_W        = 24,
  parameter int A_W        = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic                  ev_on,
  input  logic [6:0]            ev_note,
  input  logic [A_W-1:0]        ev_amp,
  output logic [F_W-1:0]        F_out,
  output logic [A_W-1:0]        A_out,
  output logic [NUM_VOICES-1:0] loadF,
  output logic [NUM_VOICES-1:0] loadA,
  output logic [NUM_VOICES-1:0] key_on,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITE} state_e;

  state_e                  state_q;
  logic                    on_q;
  logic [6:0]              note_q;
  logic [A_W-1:0]          amp_q;
  logic [6:0]              vnote_q [NUM_VOICES];
  logic [7:0]              age_q   [NUM_VOICES];
  logic [NUM_VOICES-1:0]   key_on_q;
  logic [IDX_W-1:0]        sel_q;
  logic                    hit_q;
  logic [F_W-1:0]          f_q;
  logic [A_W-1:0]          a_q;
  logic [NUM_VOICES-1:0]   load_q;

  // Top-octave (notes 120..131) phase increments at Fs = 48 kHz.
  function automatic logic [23:0] base_lut(input logic [3:0] s);
    case (s)
      4'd0:    base_lut = 24'd2926232;
      4'd1:    base_lut = 24'd3100235;
      4'd2:    base_lut = 24'd3284585;
      4'd3:    base_lut = 24'd3479896;
      4'd4:    base_lut = 24'd3686822;
      4'd5:    base_lut = 24'd3906052;
      4'd6:    base_lut = 24'd4138318;
      4'd7:    base_lut = 24'd4384395;
      4'd8:    base_lut = 24'd4645104;
      4'd9:    base_lut = 24'd4921317;
      4'd10:   base_lut = 24'd5213953;
      4'd11:   base_lut = 24'd5523991;
      default: base_lut = 24'd0;
    endcase
  endfunction

  logic [3:0]       semi_d;
  logic [3:0]       oct_d;
  logic [F_W-1:0]   f_d;
  logic             match_found;
  logic             free_found;
  logic [IDX_W-1:0] match_idx;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] old_idx;
  logic [7:0]       old_age;
  logic [IDX_W-1:0] sel_d;

  always_comb begin
    semi_d = 4'(note_q % 7'd12);
    oct_d  = 4'(note_q / 7'd12);
    f_d    = F_W'(base_lut(semi_d) >> (4'd10 - oct_d));
  end

  // Retrigger beats free voice beats steal; strict compare keeps lowest index on age ties.
  always_comb begin
    match_found = 1'b0;
    free_found  = 1'b0;
    match_idx   = '0;
    free_idx    = '0;
    old_idx     = '0;
    old_age     = age_q[0];
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (key_on_q[i] && (vnote_q[i] == note_q) && !match_found) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
      if (!key_on_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_idx = IDX_W'(i);
      end
    end
    sel_d = match_found ? match_idx : (free_found ? free_idx : old_idx);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= IDLE;
      on_q     <= 1'b0;
      note_q   <= '0;
      amp_q    <= '0;
      key_on_q <= '0;
      sel_q    <= '0;
      hit_q    <= 1'b0;
      f_q      <= '0;
      a_q      <= '0;
      load_q   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vnote_q[i] <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      load_q <= '0;
      case (state_q)
        IDLE: begin
          if (ev_valid) begin
            on_q    <= ev_on && (ev_amp != '0);
            note_q  <= ev_note;
            amp_q   <= ev_amp;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          sel_q <= on_q ? sel_d : match_idx;
          hit_q <= on_q || match_found;
          if (on_q) begin
            f_q    <= f_d;
            a_q    <= amp_q;
            load_q <= NUM_VOICES'(1) << sel_d;
          end
          state_q <= WRITE;
        end
        WRITE: begin
          if (hit_q && on_q) begin
            key_on_q[sel_q] <= 1'b1;
            vnote_q[sel_q]  <= note_q;
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IDX_W'(i) == sel_q) begin
                age_q[i] <= '0;
              end else if (key_on_q[i] && (age_q[i] != 8'hFF)) begin
                age_q[i] <= age_q[i] + 8'd1;
              end
            end
          end else if (hit_q) begin
            key_on_q[sel_q] <= 1'b0;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ev_ready = Reset && (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign F_out    = f_q;
  assign A_out    = a_q;
  assign loadF    = load_q;
  assign loadA    = load_q;
  assign key_on   = key_on_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard bench for voice_allocator
// Accepted events feed a reference model; expected write/gate results are queued and checked.
module tb_voice_allocator;

  localparam int NV = 4;

  logic          Clk;
  logic          Reset;
  logic          ev_valid;
  logic          ev_ready;
  logic          ev_on;
  logic [6:0]    ev_note;
  logic [15:0]   ev_amp;
  logic [23:0]   F_out;
  logic [15:0]   A_out;
  logic [NV-1:0] loadF;
  logic [NV-1:0] loadA;
  logic [NV-1:0] key_on;
  logic          busy;

  voice_allocator #(.NUM_VOICES(NV), .F_W(24), .A_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_amp(ev_amp), .F_out(F_out),
    .A_out(A_out), .loadF(loadF), .loadA(loadA), .key_on(key_on), .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int            due;
    logic [NV-1:0] load;
    logic [23:0]   f;
    logic [15:0]   a;
    logic [NV-1:0] key;
  } exp_t;

  exp_t wq[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rst_cnt  = 0;
  int acc_cnt  = 0;
  int sent_cnt = 0;
  int last_acc = 0;

  int            base_t [12] = '{2926232, 3100235, 3284585, 3479896, 3686822, 3906052,
                                 4138318, 4384395, 4645104, 4921317, 5213953, 5523991};
  int            mnote [NV];
  int            mage  [NV];
  logic [NV-1:0] mkey;
  logic [23:0]   mf;
  logic [15:0]   ma;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      mnote[i] = 0;
      mage[i]  = 0;
    end
    mkey = '0;
    mf   = '0;
    ma   = '0;
  endtask

  task automatic model_event(input logic on, input logic [6:0] n, input logic [15:0] a,
                             output exp_t e);
    int v;
    int best;
    v = -1;
    e.load = '0;
    for (int i = 0; i < NV; i++)
      if (v < 0 && mkey[i] && mnote[i] == int'(n)) v = i;
    if (on && a != 16'h0) begin
      for (int i = 0; i < NV; i++)
        if (v < 0 && !mkey[i]) v = i;
      if (v < 0) begin
        best = 0;
        for (int i = 1; i < NV; i++)
          if (mage[i] > mage[best]) best = i;
        v = best;
      end
      e.load   = NV'(1 << v);
      mf       = 24'(base_t[int'(n) % 12] >> (10 - int'(n) / 12));
      ma       = a;
      mnote[v] = int'(n);
      for (int i = 0; i < NV; i++) begin
        if (i == v) mage[i] = 0;
        else if (mkey[i] && mage[i] < 255) mage[i] = mage[i] + 1;
      end
      mkey[v] = 1'b1;
    end else if (v >= 0) begin
      mkey[v] = 1'b0;
    end
    e.f   = mf;
    e.a   = ma;
    e.key = mkey;
  endtask

  always @(negedge Clk) begin
    exp_t e;
    cyc++;
    if (!Reset) begin
      wq.delete();
      model_reset();
      if (rst_cnt > 0) begin
        check_eq("rst_load", {loadF, loadA}, '0);
        check_eq("rst_key_on", key_on, '0);
        check_eq("rst_f", F_out, '0);
        check_eq("rst_a", A_out, '0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", ev_ready, 0);
      end
      rst_cnt++;
    end else begin
      if (rst_cnt > 0) check_eq("ready_after_rst", ev_ready, 1);
      rst_cnt = 0;
      if (wq.size() > 0 && wq[0].due == cyc) begin
        check_eq("loadF", loadF, wq[0].load);
        check_eq("loadA", loadA, wq[0].load);
        check_eq("F_out", F_out, wq[0].f);
        check_eq("A_out", A_out, wq[0].a);
        check_eq("busy_write", busy, 1);
        check_eq("ready_write", ev_ready, 0);
      end else begin
        check_eq("idle_strobes", {loadF, loadA}, '0);
      end
      if (wq.size() > 0 && wq[0].due + 1 == cyc) begin
        check_eq("key_on", key_on, wq[0].key);
        check_eq("ready_after", ev_ready, 1);
        void'(wq.pop_front());
      end
      if (ev_valid && ev_ready) begin
        model_event(ev_on, ev_note, ev_amp, e);
        e.due = cyc + 2;
        wq.push_back(e);
        acc_cnt++;
        last_acc = cyc;
      end
    end
  end

  task automatic send(input logic on, input logic [6:0] n, input logic [15:0] a, input bit keep);
    bit ok;
    ok       = 1'b0;
    ev_on    = on;
    ev_note  = n;
    ev_amp   = a;
    ev_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge Clk);
      if (ev_ready) ok = 1'b1;
      @(posedge Clk);
      #1;
    end
    if (!ok) check_eq("send_timeout", 0, 1);
    if (!keep) ev_valid = 1'b0;
    sent_cnt++;
  endtask

  initial begin
    int t0, t1, t2;
    Reset    = 1'b0;
    ev_valid = 1'b0;
    ev_on    = 1'b0;
    ev_note  = '0;
    ev_amp   = '0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;

    send(1, 7'd69, 16'h4000, 0);
    send(0, 7'd69, 16'h0000, 0);
    send(1, 7'd60, 16'h0100, 0);
    send(1, 7'd64, 16'h0200, 0);
    send(1, 7'd67, 16'h0300, 0);
    send(1, 7'd72, 16'h0400, 0);
    send(1, 7'd76, 16'h0500, 0);
    send(1, 7'd64, 16'h1000, 0);
    send(0, 7'd64, 16'h7777, 0);
    send(0, 7'd99, 16'h0000, 0);
    send(1, 7'd67, 16'h0000, 0);

    send(1, 7'd0,   16'h1111, 1);
    t0 = last_acc;
    send(1, 7'd127, 16'h2222, 1);
    t1 = last_acc;
    send(1, 7'd120, 16'h3333, 0);
    t2 = last_acc;
    check_eq("bp_gap1", t1 - t0, 3);
    check_eq("bp_gap2", t2 - t1, 3);

    for (int s = 0; s < 12; s++)
      send(1, 7'(12 * ((s * 7) % 11) + s), 16'(s * 100 + 1), 0);
    for (int s = 0; s < 12; s += 3)
      send(0, 7'(12 * ((s * 7) % 11) + s), 16'h0, 0);

    send(1, 7'd50, 16'h5555, 0);
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    send(1, 7'd69, 16'h0042, 0);
    repeat (5) @(posedge Clk);
    #1;
    check_eq("accepted_once", acc_cnt, sent_cnt);
    check_eq("queue_drained", wq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
